// File: rtl/csi2_pkt_crc_check_pkg.sv
// Shared types and constants for the CSI-2 packet parser / payload CRC checker.
package csi2_crc_pkg;

    typedef enum logic [2:0] {
        StHdr,
        StPayload,
        StCrcLo,
        StCrcHi,
        StDrop
    } state_e;

    localparam logic [15:0] CRC_POLY_REFL   = 16'h8408;
    localparam logic [15:0] CRC_SEED        = 16'hFFFF;
    localparam logic [5:0]  LONG_PKT_DT_MIN = 6'h10;

    // Common data types; anything at or above LONG_PKT_DT_MIN carries a payload.
    localparam logic [5:0] DT_FS     = 6'h00;
    localparam logic [5:0] DT_FE     = 6'h01;
    localparam logic [5:0] DT_LS     = 6'h02;
    localparam logic [5:0] DT_LE     = 6'h03;
    localparam logic [5:0] DT_NULL   = 6'h10;
    localparam logic [5:0] DT_BLANK  = 6'h11;
    localparam logic [5:0] DT_EMBED  = 6'h12;
    localparam logic [5:0] DT_YUV422 = 6'h1E;
    localparam logic [5:0] DT_RGB888 = 6'h24;
    localparam logic [5:0] DT_RAW8   = 6'h2A;
    localparam logic [5:0] DT_RAW10  = 6'h2B;
    localparam logic [5:0] DT_RAW12  = 6'h2C;

    function automatic logic is_long_pkt(input logic [5:0] dt);
        return dt >= LONG_PKT_DT_MIN;
    endfunction

endpackage

// File: rtl/csi2_pkt_crc_check_if.sv
// Byte-wide AXI4-Stream bundle used for both packet input and payload output.
interface axi4_stream;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/csi2_crc16_byte.sv
// Combinational CRC-16 (reflected 0x8408, LSB-first) update for one byte.
module csi2_crc16_byte
    import csi2_crc_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] crc_o
);

    logic [15:0] c;

    always_comb begin
        c = crc_i ^ {8'h00, byte_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/csi2_pkt_crc_check.sv
// Splits CSI-2 packets into header side-band fields and a payload stream,
// checking the long-packet CRC-16 and the tlast position against the header.
module csi2_pkt_crc_check
    import csi2_crc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    axi4_stream.slave   pkt_i,
    axi4_stream.master  payload_o,
    output logic        hdr_valid_o,
    output logic [1:0]  vc_o,
    output logic [5:0]  dt_o,
    output logic [15:0] wc_o,
    output logic        crc_err_o,
    output logic        len_err_o
);

    state_e      state_q, state_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0] pay_cnt_q, pay_cnt_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_lo_q, crc_lo_d;
    logic [7:0]  di_q, di_d;
    logic [7:0]  wc_lo_q, wc_lo_d;
    logic [7:0]  wc_hi_q, wc_hi_d;
    logic [1:0]  vc_q, vc_d;
    logic [5:0]  dt_q, dt_d;
    logic [15:0] wc_q, wc_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic        hdr_valid_q, hdr_valid_d;
    logic        crc_err_q, crc_err_d;
    logic        len_err_q, len_err_d;

    logic        pkt_ready;
    logic        accept;
    logic [15:0] hdr_wc;
    logic [15:0] crc_next;

    csi2_crc16_byte u_crc16 (
        .crc_i  (crc_q),
        .byte_i (pkt_i.tdata),
        .crc_o  (crc_next)
    );

    // Only the payload path can stall: one output register, no skid buffer.
    assign pkt_ready = (state_q == StPayload) ? (!out_valid_q || payload_o.tready) : 1'b1;
    assign accept    = pkt_i.tvalid && pkt_ready;
    assign hdr_wc    = {wc_hi_q, wc_lo_q};

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        crc_d       = crc_q;
        crc_lo_d    = crc_lo_q;
        di_d        = di_q;
        wc_lo_d     = wc_lo_q;
        wc_hi_d     = wc_hi_q;
        vc_d        = vc_q;
        dt_d        = dt_q;
        wc_d        = wc_q;
        out_valid_d = out_valid_q && !payload_o.tready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        hdr_valid_d = 1'b0;
        crc_err_d   = 1'b0;
        len_err_d   = 1'b0;

        unique case (state_q)
            StHdr: begin
                if (accept) begin
                    if (hdr_cnt_q != 2'd3) begin
                        case (hdr_cnt_q)
                            2'd0:    di_d    = pkt_i.tdata;
                            2'd1:    wc_lo_d = pkt_i.tdata;
                            default: wc_hi_d = pkt_i.tdata;
                        endcase
                        if (pkt_i.tlast) begin
                            len_err_d = 1'b1;
                            hdr_cnt_d = 2'd0;
                        end else begin
                            hdr_cnt_d = hdr_cnt_q + 2'd1;
                        end
                    end else begin
                        // ECC byte: header is complete.
                        hdr_cnt_d   = 2'd0;
                        hdr_valid_d = 1'b1;
                        vc_d        = di_q[7:6];
                        dt_d        = di_q[5:0];
                        wc_d        = hdr_wc;
                        crc_d       = CRC_SEED;
                        if (!is_long_pkt(di_q[5:0])) begin
                            if (!pkt_i.tlast) begin
                                len_err_d = 1'b1;
                                state_d   = StDrop;
                            end
                        end else if (pkt_i.tlast) begin
                            len_err_d = 1'b1;
                        end else if (hdr_wc == 16'd0) begin
                            state_d = StCrcLo;
                        end else begin
                            pay_cnt_d = hdr_wc;
                            state_d   = StPayload;
                        end
                    end
                end
            end

            StPayload: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pkt_i.tdata;
                    out_last_d  = pkt_i.tlast || (pay_cnt_q == 16'd1);
                    crc_d       = crc_next;
                    pay_cnt_d   = pay_cnt_q - 16'd1;
                    // tlast anywhere in the payload is early: the CRC is still owed.
                    if (pkt_i.tlast) begin
                        len_err_d = 1'b1;
                        state_d   = StHdr;
                    end else if (pay_cnt_q == 16'd1) begin
                        state_d = StCrcLo;
                    end
                end
            end

            StCrcLo: begin
                if (accept) begin
                    if (pkt_i.tlast) begin
                        len_err_d = 1'b1;
                        state_d   = StHdr;
                    end else begin
                        crc_lo_d = pkt_i.tdata;
                        state_d  = StCrcHi;
                    end
                end
            end

            StCrcHi: begin
                if (accept) begin
                    if (!pkt_i.tlast) begin
                        len_err_d = 1'b1;
                        state_d   = StDrop;
                    end else begin
                        crc_err_d = ({pkt_i.tdata, crc_lo_q} != crc_q);
                        state_d   = StHdr;
                    end
                end
            end

            StDrop: begin
                if (accept && pkt_i.tlast) begin
                    state_d = StHdr;
                end
            end

            default: state_d = StHdr;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StHdr;
            hdr_cnt_q   <= 2'd0;
            pay_cnt_q   <= 16'd0;
            crc_q       <= CRC_SEED;
            crc_lo_q    <= 8'd0;
            di_q        <= 8'd0;
            wc_lo_q     <= 8'd0;
            wc_hi_q     <= 8'd0;
            vc_q        <= 2'd0;
            dt_q        <= 6'd0;
            wc_q        <= 16'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_last_q  <= 1'b0;
            hdr_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            crc_q       <= crc_d;
            crc_lo_q    <= crc_lo_d;
            di_q        <= di_d;
            wc_lo_q     <= wc_lo_d;
            wc_hi_q     <= wc_hi_d;
            vc_q        <= vc_d;
            dt_q        <= dt_d;
            wc_q        <= wc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            hdr_valid_q <= hdr_valid_d;
            crc_err_q   <= crc_err_d;
            len_err_q   <= len_err_d;
        end
    end

    assign pkt_i.tready     = pkt_ready;
    assign payload_o.tvalid = out_valid_q;
    assign payload_o.tdata  = out_data_q;
    assign payload_o.tlast  = out_last_q;
    assign hdr_valid_o      = hdr_valid_q;
    assign vc_o             = vc_q;
    assign dt_o             = dt_q;
    assign wc_o             = wc_q;
    assign crc_err_o        = crc_err_q;
    assign len_err_o        = len_err_q;

endmodule

// File: tb/tb_csi2_pkt_crc_check.sv
// Scoreboard bench for csi2_pkt_crc_check: stimulus pushes expectations, a monitor pops them.
module tb_csi2_pkt_crc_check;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
    } hdr_t;
    typedef struct packed {
        logic crc;
        logic len;
    } err_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hdr_valid, crc_err, len_err;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        pay_rdy = 1'b1;
    bit          rand_en = 1'b0;

    logic [8:0]  pay_q[$];
    hdr_t        hdr_q[$];
    err_t        err_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    axi4_stream pkt_if ();
    axi4_stream pay_if ();

    assign pay_if.tready = pay_rdy;

    csi2_pkt_crc_check dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .pkt_i       (pkt_if),
        .payload_o   (pay_if),
        .hdr_valid_o (hdr_valid),
        .vc_o        (vc),
        .dt_o        (dt),
        .wc_o        (wc),
        .crc_err_o   (crc_err),
        .len_err_o   (len_err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] got);
        n_vec++;
        n_err++;
        $display("FAIL %s: got unexpected %h, expected nothing", name, got);
    endtask

    // Reference CRC: bit-serial, feedback taken from crc LSB xor data bit.
    function automatic logic [15:0] ref_crc(input bq_t b);
        logic [15:0] c = 16'hFFFF;
        logic        fb;
        foreach (b[i]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[i][j];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (pay_if.tvalid && pay_if.tready) begin
                if (pay_q.size() == 0) unexpected("payload", {23'd0, pay_if.tlast, pay_if.tdata});
                else chk("payload", {23'd0, pay_if.tlast, pay_if.tdata}, {23'd0, pay_q.pop_front()});
            end
            if (hdr_valid) begin
                if (hdr_q.size() == 0) unexpected("header", {8'd0, vc, dt, wc});
                else chk("header", {8'd0, vc, dt, wc}, {8'd0, hdr_q.pop_front()});
            end
            if (crc_err || len_err) begin
                if (err_q.size() == 0) unexpected("err_pulse", {30'd0, crc_err, len_err});
                else chk("err_pulse", {30'd0, crc_err, len_err}, {30'd0, err_q.pop_front()});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        pay_rdy = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic wait_accept();
        int n = 0;
        forever begin
            @(negedge clk);
            if (pkt_if.tready) begin
                @(posedge clk);
                #1;
                return;
            end
            n++;
            if (n > 5000) begin
                n_vec++;
                n_err++;
                $display("FAIL input_accept: got no tready in 5000 cycles, expected tready");
                return;
            end
        end
    endtask

    task automatic send_seq(input bq_t b, input int last_idx);
        foreach (b[i]) begin
            pkt_if.tvalid = 1'b1;
            pkt_if.tdata  = b[i];
            pkt_if.tlast  = (i == last_idx);
            wait_accept();
        end
        pkt_if.tvalid = 1'b0;
        pkt_if.tlast  = 1'b0;
    endtask

    // Full long packet: header, payload, CRC bytes, tlast on CRC_HI.
    task automatic long_pkt(input logic [7:0] di, input bq_t pl, input logic [7:0] clo,
                            input logic [7:0] chi, input bit exp_crc_err);
        bq_t         b;
        logic [15:0] n = 16'(pl.size());
        b = '{di, n[7:0], n[15:8], 8'h00};
        foreach (pl[i]) begin
            b.push_back(pl[i]);
            pay_q.push_back({(i == pl.size() - 1), pl[i]});
        end
        b.push_back(clo);
        b.push_back(chi);
        hdr_q.push_back({di[7:6], di[5:0], n});
        if (exp_crc_err) err_q.push_back(2'b10);
        send_seq(b, b.size() - 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (pay_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_payload_left"}, pay_q.size(), 0);
        chk({name, "_header_left"}, hdr_q.size(), 0);
        chk({name, "_err_left"}, err_q.size(), 0);
    endtask

    initial begin
        bq_t         p1, p2, b;
        logic [15:0] c;

        pkt_if.tvalid = 1'b0;
        pkt_if.tdata  = 8'h00;
        pkt_if.tlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tvalid", pay_if.tvalid, 0);
        chk("rst_hdr_valid", hdr_valid, 0);
        chk("rst_crc_err", crc_err, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_fields", {vc, dt, wc}, 0);
        chk("rst_tready", pkt_if.tready, 1);
        @(posedge clk);
        #1;

        p1 = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
               8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
        p2 = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7, 8'h4F, 8'h82, 8'h78, 8'hC5,
               8'h82, 8'hE0, 8'h8C, 8'h70, 8'hD2, 8'h3C, 8'h78, 8'hE9, 8'hFF, 8'h00, 8'h00, 8'h01};

        long_pkt(8'h2A, p1, 8'hF0, 8'h00, 1'b0);
        drain("long_crc_f000");
        long_pkt(8'h2A, p2, 8'h69, 8'hE5, 1'b0);
        drain("long_crc_e569");
        long_pkt(8'h2A, p2, 8'h69, 8'hE4, 1'b1);
        drain("long_crc_bad");

        // Short FS packet.
        hdr_q.push_back({2'd0, 6'h00, 16'h0001});
        b = '{8'h00, 8'h01, 8'h00, 8'h00};
        send_seq(b, 3);
        drain("short_fs");

        // Long WC=8 truncated after 5 payload bytes, then a short FE on VC1.
        hdr_q.push_back({2'd0, 6'h2A, 16'd8});
        b = '{8'h2A, 8'h08, 8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        for (int i = 4; i < 9; i++) pay_q.push_back({(i == 8), b[i]});
        err_q.push_back(2'b01);
        send_seq(b, 8);
        hdr_q.push_back({2'd1, 6'h01, 16'h0001});
        b = '{8'h41, 8'h01, 8'h00, 8'h00};
        send_seq(b, 3);
        drain("early_payload_tlast");

        // tlast on CRC_LO.
        hdr_q.push_back({2'd0, 6'h2A, 16'd2});
        pay_q.push_back({1'b0, 8'h11});
        pay_q.push_back({1'b1, 8'h22});
        err_q.push_back(2'b01);
        b = '{8'h2A, 8'h02, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33};
        send_seq(b, 6);
        drain("early_crc_lo_tlast");

        // 1000-byte payload under random output backpressure.
        b.delete();
        for (int i = 0; i < 1000; i++) b.push_back(8'((i * 7 + 3) ^ (i >> 3)));
        c = ref_crc(b);
        rand_en = 1'b1;
        long_pkt(8'h2B, b, c[7:0], c[15:8], 1'b0);
        drain("backpressure_1000");
        rand_en = 1'b0;

        // WC=0 long packet: CRC is the seed.
        b.delete();
        long_pkt(8'h2A, b, 8'hFF, 8'hFF, 1'b0);
        drain("long_wc0");

        // Short packet missing tlast, junk dropped, then a clean LS.
        hdr_q.push_back({2'd0, 6'h00, 16'h0001});
        err_q.push_back(2'b01);
        b = '{8'h00, 8'h01, 8'h00, 8'h00};
        send_seq(b, -1);
        b = '{8'hAA, 8'hBB, 8'hCC};
        send_seq(b, 2);
        hdr_q.push_back({2'd0, 6'h02, 16'h0005});
        b = '{8'h02, 8'h05, 8'h00, 8'h00};
        send_seq(b, 3);
        drain("short_no_tlast_drop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/csi2_pkt_crc_check.md
# csi2_pkt_crc_check

Byte-wide CSI-2 packet parser and payload CRC checker sitting between the header ECC stage and the pixel unpacker. It splits each ECC-corrected packet into header side-band fields and a payload-only AXI4-Stream. It checks the long-packet CRC-16 and emits the `crc_err` and length-error pulses consumed by the statistics accumulator.

## Interface
- No parameters; data path fixed at 8 bits.
- `clk_i` in 1: byte clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `pkt_i` axi4_stream.slave, 8-bit tdata: packet bytes, tlast on final byte of each packet.
- `payload_o` axi4_stream.master, 8-bit tdata: long-packet payload bytes only, tlast on final payload byte.
- `hdr_valid_o` out 1: one-cycle pulse, header fields valid.
- `vc_o` out 2: virtual channel (DI[7:6]).
- `dt_o` out 6: data type (DI[5:0]).
- `wc_o` out 16: word count (short packet: data field).
- `crc_err_o` out 1: one-cycle pulse, CRC mismatch.
- `len_err_o` out 1: one-cycle pulse, tlast position inconsistent with header.

## Operation
- Packet format: DI, WC_lo, WC_hi, ECC, then for long packets (dt ≥ 0x10) WC payload bytes, CRC_lo, CRC_hi. Short packets (dt < 0x10) are 4 bytes.
- FSM states:
  - HDR: byte counter 0..3.
  - PAYLOAD: down-counter loaded with WC.
  - CRC_LO
  - CRC_HI
  - DROP
- HDR: byte 3 accepted → pulse `hdr_valid_o`.
  - Short packet: tlast must be 1, stay in HDR.
  - Long packet with WC=0 → CRC_LO.
  - Otherwise → PAYLOAD.
  - CRC register seeded to 0xFFFF.
- CRC-16: poly x^16+x^12+x^5+1, reflected form 0x8408, LSB-first, seed 0xFFFF, no final XOR. Updated per payload byte. Received CRC is CRC_lo | CRC_hi<<8.
- CRC_HI accepted: compare and pulse `crc_err_o` on mismatch → HDR.
- Length errors, each pulsing `len_err_o`:
  - tlast=1 before the expected last byte in HDR or CRC_LO → HDR, no CRC check.
  - tlast=1 on a non-final payload byte → byte forwarded with tlast=1, → HDR, no CRC check.
  - tlast=0 on the expected last byte (HDR byte 3 short, CRC_HI) → DROP. DROP discards bytes until tlast accepted → HDR.
- `payload_o.tlast` asserted on payload byte WC-1.
- `vc_o`/`dt_o`/`wc_o` hold until the next header completes.

## Timing
- `pkt_i.tready`:
  - PAYLOAD: `!payload_o.tvalid || payload_o.tready` (single skid-free register stage).
  - All other states: 1.
- Payload latency: 1 cycle from `pkt_i` acceptance to `payload_o.tvalid`.
- `payload_o.tvalid`/`tdata`/`tlast` hold stable while `tready`=0.
- `hdr_valid_o`: registered, cycle after byte 3 accepted.
- `crc_err_o`: registered, cycle after CRC_HI accepted.
- `len_err_o`: registered, cycle after the offending byte.
- Reset values:
  - State HDR, counters 0, CRC 0xFFFF.
  - `payload_o.tvalid`=0, all pulses 0.
  - `vc_o`/`dt_o`/`wc_o`=0.
- Reset mid-packet: all state lost. Remaining bytes of the interrupted packet are parsed as a new header (upstream is reset together).
- WC=0xFFFF is handled without counter overflow.

## Structure
- Package `csi2_crc_pkg`:
  - state enum.
  - CRC_POLY_REFL=16'h8408, CRC_SEED=16'hFFFF.
  - LONG_PKT_DT_MIN=6'h10.
  - DT constants.
- Sub-module `csi2_crc16_byte`: combinational 16-bit CRC byte update (crc_i, byte_i → crc_o), reusable by a future multi-lane checker.

## Test plan
- Long packet DT=0x2A, WC=24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01, CRC bytes F0 00 → 24 payload bytes out, tlast on 24th, `hdr_valid_o` with dt=0x2A, wc=24, no `crc_err_o`.
- Same stream with payload FF 00 00 00 1E F0 1E C7 4F 82 78 C5 82 E0 8C 70 D2 3C 78 E9 FF 00 00 01, CRC 69 E5 → pass. Same payload with CRC 69 E4 → single `crc_err_o` pulse.
- Short packet FS: DI=0x00, WC=0x0001, tlast on byte 4 → `hdr_valid_o`, dt=0, wc=1, no payload, no errors.
- Long packet WC=8 with tlast on payload byte 5 → 5 bytes out (tlast on 5th), one `len_err_o`, no `crc_err_o`. Next packet parses correctly.
- Random `payload_o.tready` backpressure (50%) over a 1000-byte packet → output byte-exact, CRC pass, no drops or duplicates.
- Long packet WC=0, CRC FF FF → pass. Then short packet without tlast followed by 3 junk bytes with tlast → `len_err_o`, junk discarded, following packet parsed correctly.
